weight_pingpong_buff: RTL
=========================

# weight_pingpong_buff

Double-banked (ping-pong) weight buffer feeding the PE array of the convolution accelerator. One bank is filled from the weight loader while the other bank streams its kernel to the PEs, repeated a programmable number of times. Kernel length, data width and depth are parametrised. Valid/ready handshakes run on both sides.

## Interface
- DATA_WIDTH, 16, weight word width
- DEPTH, 16, words per bank (2..255)
- clk  in  1  single clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous abort; all banks EMPTY, pointers 0; contents kept
- cfg_len  in  8  kernel length in words; sampled on the first accepted beat of each bank load
- cfg_repeat  in  8  stream passes per load; sampled with cfg_len
- wr_valid  in  1  write beat valid
- wr_ready  out  1  write bank can accept
- wr_data  in  DATA_WIDTH  weight word
- rd_valid  out  1  read beat available
- rd_ready  in  1  PE side accepts
- rd_data  out  DATA_WIDTH  current weight
- rd_last  out  1  last word of a pass
- rd_final  out  1  last word of the last pass; bank released on this handshake
- full_cnt  out  2  number of banks FULL or DRAINING (0..2)

## Operation
- Two banks, each DEPTH x DATA_WIDTH registers, zeroed by reset only.
- Per-bank state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY. Per-bank stored len and rep.
- Length rule: len = cfg_len clamped to 1..DEPTH (0 -> 1, >DEPTH -> DEPTH). Repeat rule: rep = cfg_repeat, with 0 -> 1.
- Write pointer wb (reset 0), word pointer wr_ptr. wr_ready = state[wb] is EMPTY or FILLING.
- Write handshake (wr_valid & wr_ready): mem[wb][wr_ptr] <= wr_data. On the first beat (EMPTY): latch len and rep; state goes FILLING. When wr_ptr == len-1: state goes FULL, wr_ptr <= 0, wb toggles. Otherwise wr_ptr increments.
- Read pointer rb (reset 0), word pointer rd_ptr, pass counter pass_cnt.
- rd_valid = state[rb] is FULL or DRAINING.
- rd_data = mem[rb][rd_ptr]. Combinational from registers. Stable while rd_valid & !rd_ready.
- rd_last = rd_valid & (rd_ptr == len[rb]-1).
- rd_final = rd_last & (pass_cnt == rep[rb]-1).
- Read handshake: the first beat moves FULL to DRAINING.
  - Not rd_last: rd_ptr increments.
  - rd_last but not final: rd_ptr <= 0 and pass_cnt increments.
  - rd_final: state[rb] <= EMPTY, rd_ptr <= 0, pass_cnt <= 0, rb toggles.
- Write and read sides are independent. A bank may be written and the other read in the same cycle.
- clear has priority over any handshake in the same cycle. It sets both states EMPTY, wb = rb = 0, and zeroes all pointers and counters.
- A single-word kernel (len 1) makes every read beat rd_last.

## Timing
- Reset values: wr_ready=1, rd_valid=0, rd_data=0, rd_last=0, rd_final=0, full_cnt=0.
- Fill-to-read latency: the last write beat is accepted at edge N; rd_valid rises after edge N (visible in cycle N+1).
- Release-to-write: the rd_final handshake at edge M; the released bank is EMPTY after edge M, so wr_ready can rise in cycle M+1.
- Throughput: one word per cycle on each side. Back-to-back loads alternate banks with no bubble while the other bank is EMPTY.
- Both banks FULL: wr_ready=0 until a release. Both banks EMPTY: rd_valid=0.
- rd_valid never drops without a handshake, except on clear or reset.
- Asynchronous reset mid-stream: all outputs go to reset values immediately; contents are zeroed.
- cfg_len and cfg_repeat changes during FILLING/DRAINING do not affect that bank.

## Test plan
- Reset, then load 9 words 1..9 with cfg_len=9, cfg_repeat=1, rd_ready=1:
  - rd_valid rises the cycle after the 9th beat; rd_data reads 1..9.
  - rd_last and rd_final on word 9; full_cnt returns to 0.
- Load bank0 = 1..4 and bank1 = 11..14 (len 4, repeat 3) with rd_ready=0:
  - wr_ready falls after the 8th beat; full_cnt=2.
  - Release rd_ready: output is 1..4 three times with rd_last every 4th word, then 11..14 three times.
  - wr_ready rises the cycle after the 12th read.
- Random rd_ready backpressure with len 5, repeat 2: rd_data holds while stalled; no word is lost or duplicated (20 words total over two loads).
- cfg_len=0 and cfg_len=40 with DEPTH=16: banks take 1 and 16 words respectively; cfg_repeat=0 streams once.
- clear asserted mid-fill (3 of 9 words) and mid-drain: next cycle rd_valid=0, wr_ready=1, full_cnt=0; a fresh load of 9 words reads back correctly from bank0.
- rstn asserted asynchronously mid-drain: outputs go to reset values without waiting for a clock edge; after release, rd_data=0 and a reload works.

Source files
------------

// File: rtl/weight_pingpong_buff.sv
// weight_pingpong_buff: two-bank weight buffer between the weight loader and
// the PE array. One bank fills while the other streams its kernel to the PEs
// a programmable number of passes. Banks are used strictly in alternation.
module weight_pingpong_buff #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clear_i,
  input  logic [7:0]            cfg_len_i,
  input  logic [7:0]            cfg_repeat_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o,
  output logic                  rd_final_o,
  output logic [1:0]            full_cnt_o
);

  localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_FILLING  = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;
  localparam logic [1:0] ST_DRAINING = 2'd3;

  logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

  logic [1:0]       state_q [2];
  logic [1:0]       state_d [2];
  logic [7:0]       len_q [2];
  logic [7:0]       len_d [2];
  logic [7:0]       rep_q [2];
  logic [7:0]       rep_d [2];
  logic             wb_q, wb_d;
  logic             rb_q, rb_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [7:0]       passCnt_q, passCnt_d;

  logic [7:0] cfgLenClamped;
  logic [7:0] cfgRepClamped;
  logic [7:0] wrLen;
  logic       wrLastBeat;
  logic       wrFire;
  logic       rdFire;
  logic       busy0;
  logic       busy1;

  // A zero length or repeat still means one word / one pass; lengths beyond
  // the bank size are cut to the bank size.
  assign cfgLenClamped = (cfg_len_i == 8'd0)   ? 8'd1 :
                         (cfg_len_i > DEPTH_B) ? DEPTH_B : cfg_len_i;
  assign cfgRepClamped = (cfg_repeat_i == 8'd0) ? 8'd1 : cfg_repeat_i;

  assign wr_ready_o = (state_q[wb_q] == ST_EMPTY) || (state_q[wb_q] == ST_FILLING);
  assign rd_valid_o = (state_q[rb_q] == ST_FULL)  || (state_q[rb_q] == ST_DRAINING);
  assign rd_data_o  = mem_q[rb_q][rdPtr_q];
  assign rd_last_o  = rd_valid_o && (8'(rdPtr_q) == (len_q[rb_q] - 8'd1));
  assign rd_final_o = rd_last_o && (passCnt_q == (rep_q[rb_q] - 8'd1));

  assign wrFire = wr_valid_i && wr_ready_o;
  assign rdFire = rd_valid_o && rd_ready_i;

  // The first beat of a load uses the freshly sampled length, later beats the
  // latched one, so a one-word kernel completes on its only beat.
  assign wrLen      = (state_q[wb_q] == ST_EMPTY) ? cfgLenClamped : len_q[wb_q];
  assign wrLastBeat = (8'(wrPtr_q) == (wrLen - 8'd1));

  assign busy0      = (state_q[0] == ST_FULL) || (state_q[0] == ST_DRAINING);
  assign busy1      = (state_q[1] == ST_FULL) || (state_q[1] == ST_DRAINING);
  assign full_cnt_o = 2'(busy0) + 2'(busy1);

  // Next-state for bank states, stored kernel shapes and both side pointers.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rep_d     = rep_q;
    wb_d      = wb_q;
    rb_d      = rb_q;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    passCnt_d = passCnt_q;

    if (clear_i) begin
      state_d[0] = ST_EMPTY;
      state_d[1] = ST_EMPTY;
      wb_d       = 1'b0;
      rb_d       = 1'b0;
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      passCnt_d  = '0;
    end else begin
      if (wrFire) begin
        if (state_q[wb_q] == ST_EMPTY) begin
          len_d[wb_q]   = cfgLenClamped;
          rep_d[wb_q]   = cfgRepClamped;
          state_d[wb_q] = ST_FILLING;
        end
        if (wrLastBeat) begin
          state_d[wb_q] = ST_FULL;
          wrPtr_d       = '0;
          wb_d          = ~wb_q;
        end else begin
          wrPtr_d = wrPtr_q + PTR_W'(1);
        end
      end

      if (rdFire) begin
        if (rd_final_o) begin
          state_d[rb_q] = ST_EMPTY;
          rdPtr_d       = '0;
          passCnt_d     = '0;
          rb_d          = ~rb_q;
        end else begin
          state_d[rb_q] = ST_DRAINING;
          if (rd_last_o) begin
            rdPtr_d   = '0;
            passCnt_d = passCnt_q + 8'd1;
          end else begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
          end
        end
      end
    end
  end

  // Control registers; reset leaves both banks empty and pointing at bank 0.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q[0] <= ST_EMPTY;
      state_q[1] <= ST_EMPTY;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      rep_q[0]   <= '0;
      rep_q[1]   <= '0;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      passCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rep_q     <= rep_d;
      wb_q      <= wb_d;
      rb_q      <= rb_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      passCnt_q <= passCnt_d;
    end
  end

  // Bank storage: zeroed only by reset, clear leaves contents untouched.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[b][i] <= '0;
        end
      end
    end else if (wrFire && !clear_i) begin
      mem_q[wb_q][wrPtr_q] <= wr_data_i;
    end
  end

endmodule
